// File: rtl/online_div_digit_select.sv
// Radix-2 online divider: quotient-digit selection and residue recurrence.
// Consumes one borrow-save residue beat per iteration, emits one signed digit.
module online_div_digit_select #(
  parameter int NDIG = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] divisor,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] residue_upper_plus,
  input  logic [5:0] residue_upper_minus,
  input  logic [3:0] residue_plus,
  input  logic [3:0] residue_minus,
  output logic       q_valid,
  output logic       q_plus,
  output logic       q_minus,
  output logic       busy,
  output logic       done,
  output logic       rem_nonzero,
  output logic [8:0] residue_out,
  output logic       div_err
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [5:0]    d_q;
  logic [8:0]    r;
  logic [CW-1:0] cnt;
  logic          sticky;

  logic [6:0] v;
  logic [8:0] s;
  logic [8:0] diff;
  logic [8:0] r_next;
  logic       sel_p;
  logic       sel_m;
  logic       sticky_n;
  logic       beat;
  logic       last;

  assign in_ready    = (state == RUN);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign residue_out = r;

  assign beat = in_valid && in_ready;
  assign last = (cnt == CW'(NDIG - 1));

  // Upper residue collapses to a 7-bit signed value, then sign-extends.
  assign v = {1'b0, residue_upper_plus} - {1'b0, residue_upper_minus};
  assign s = r + {{2{v[6]}}, v};

  // s >= 16 when non-negative; s <= -17 (9'h1EF) when negative.
  assign sel_p = !s[8] && (s >= 9'd16);
  assign sel_m =  s[8] && (s <= 9'h1EF);

  always_comb begin
    diff = s;
    unique case (1'b1)
      sel_p:   diff = s - {3'b000, d_q};
      sel_m:   diff = s + {3'b000, d_q};
      default: diff = s;
    endcase
  end

  assign r_next   = {diff[7:0], 1'b0};
  assign sticky_n = sticky | (residue_plus != residue_minus);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d_q         <= '0;
      r           <= '0;
      cnt         <= '0;
      sticky      <= 1'b0;
      q_valid     <= 1'b0;
      q_plus      <= 1'b0;
      q_minus     <= 1'b0;
      rem_nonzero <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      q_plus  <= 1'b0;
      q_minus <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem_nonzero <= 1'b0;
            if (divisor[5]) begin
              d_q     <= divisor;
              r       <= '0;
              cnt     <= '0;
              sticky  <= 1'b0;
              div_err <= 1'b0;
              state   <= RUN;
            end else begin
              div_err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            q_valid <= 1'b1;
            q_plus  <= sel_p;
            q_minus <= sel_m;
            r       <= r_next;
            sticky  <= sticky_n;
            cnt     <= cnt + 1'b1;
            if (last) begin
              rem_nonzero <= (r_next != 9'd0) | sticky_n;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_online_div_digit_select.sv
// Bench for online_div_digit_select: directed scenarios plus random
// divisions checked against an integer-arithmetic reference model.
module tb_online_div_digit_select;

  localparam int NDIG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] divisor = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] rup = '0;
  logic [5:0] rum = '0;
  logic [3:0] rp = '0;
  logic [3:0] rm = '0;
  logic       q_valid;
  logic       q_plus;
  logic       q_minus;
  logic       busy;
  logic       done;
  logic       rem_nonzero;
  logic [8:0] residue_out;
  logic       div_err;

  online_div_digit_select #(.NDIG(NDIG)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .divisor             (divisor),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .residue_upper_plus  (rup),
    .residue_upper_minus (rum),
    .residue_plus        (rp),
    .residue_minus       (rm),
    .q_valid             (q_valid),
    .q_plus              (q_plus),
    .q_minus             (q_minus),
    .busy                (busy),
    .done                (done),
    .rem_nonzero         (rem_nonzero),
    .residue_out         (residue_out),
    .div_err             (div_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_r = 0;
  int m_cnt = 0;
  int m_d = 0;
  bit m_run = 0;
  bit m_sticky = 0;
  bit m_rem = 0;
  bit m_err = 0;

  function automatic int wrap9(int x);
    int y;
    y = x & 511;
    return (y > 255) ? y - 512 : y;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(int d);
    bit ok;
    ok = (d & 32) != 0;
    @(negedge clk);
    start = 1'b1;
    divisor = 6'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    m_err = !ok;
    m_rem = 0;
    if (ok) begin
      m_run = 1;
      m_r = 0;
      m_cnt = 0;
      m_sticky = 0;
      m_d = d;
    end
    chk("start_busy", 16'(busy), 16'(ok));
    chk("start_done", 16'(done), 16'(!ok));
    chk("start_err", 16'(div_err), 16'(m_err));
    chk("start_qv", 16'(q_valid), 16'd0);
    chk("start_rem", 16'(rem_nonzero), 16'd0);
    chk("start_res", 16'(residue_out), 16'(m_r & 511));
  endtask

  task automatic beat(int up, int um, int lp, int lm, bit vld,
                      bit st = 0, int sd = 0);
    int s;
    int q;
    @(negedge clk);
    rup = 6'(up);
    rum = 6'(um);
    rp = 4'(lp);
    rm = 4'(lm);
    in_valid = vld;
    start = st;
    divisor = 6'(sd);
    #1;
    chk("in_ready", 16'(in_ready), 16'(m_run));
    chk("busy", 16'(busy), 16'(m_run));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b0;
    if (vld && m_run) begin
      s = wrap9(m_r + up - um);
      q = (s >= 16) ? 1 : (s <= -17) ? -1 : 0;
      m_r = wrap9(2 * (s - q * m_d));
      m_sticky = m_sticky | (lp != lm);
      m_cnt++;
      chk("q_valid", 16'(q_valid), 16'd1);
      chk("q_plus", 16'(q_plus), 16'(q == 1));
      chk("q_minus", 16'(q_minus), 16'(q == -1));
      chk("residue", 16'(residue_out), 16'(m_r & 511));
      chk("done", 16'(done), 16'(m_cnt == NDIG));
      if (m_cnt == NDIG) begin
        m_run = 0;
        m_rem = (m_r != 0) || m_sticky;
        chk("rem_nonzero", 16'(rem_nonzero), 16'(m_rem));
      end
    end else begin
      chk("q_valid_idle", 16'(q_valid), 16'd0);
      chk("done_idle", 16'(done), 16'd0);
    end
  endtask

  task automatic idle_chk();
    @(posedge clk);
    #1;
    chk("idle_ready", 16'(in_ready), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_qv", 16'(q_valid), 16'd0);
    chk("idle_rem", 16'(rem_nonzero), 16'(m_rem));
    chk("idle_err", 16'(div_err), 16'(m_err));
    chk("idle_res", 16'(residue_out), 16'(m_r & 511));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, 16'(in_ready), 16'd0);
    chk({tag, "_qv"}, 16'(q_valid), 16'd0);
    chk({tag, "_qp"}, 16'(q_plus), 16'd0);
    chk({tag, "_qm"}, 16'(q_minus), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_rem"}, 16'(rem_nonzero), 16'd0);
    chk({tag, "_res"}, 16'(residue_out), 16'd0);
    chk({tag, "_err"}, 16'(div_err), 16'd0);
  endtask

  initial begin
    int d;
    int lp;
    int lm;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // exact division: digits +1,-1,+1,-1, r ends at 0
    do_start(32);
    beat(20, 0, 5, 5, 1);
    beat(0, 0, 2, 2, 1);
    beat(0, 0, 0, 0, 1);
    beat(0, 0, 9, 9, 1);
    chk("exact_rem0", 16'(rem_nonzero), 16'd0);
    idle_chk();

    // wrap-around of the recurrence register
    do_start(32);
    beat(63, 0, 0, 0, 1);
    beat(63, 0, 0, 0, 1);
    beat(63, 0, 0, 0, 1);
    chk("wrap_1b2", 16'(residue_out), 16'h1B2);
    beat(0, 0, 0, 0, 1);
    idle_chk();

    // sticky from a mismatched lower pair
    do_start(32);
    beat(20, 0, 0, 0, 1);
    beat(0, 0, 3, 1, 1);
    beat(0, 0, 0, 0, 1);
    beat(0, 0, 0, 0, 1);
    chk("sticky_rem1", 16'(rem_nonzero), 16'd1);
    idle_chk();

    // stalls plus a start pulse during RUN that must be ignored
    do_start(32);
    beat(20, 0, 0, 0, 1);
    beat(50, 0, 0, 0, 0, 1, 40);
    beat(0, 0, 0, 0, 1);
    beat(0, 7, 0, 0, 1, 1, 63);
    beat(30, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 1);
    idle_chk();

    // bad divisor, then recovery
    do_start(17);
    idle_chk();
    do_start(40);
    beat(10, 3, 0, 0, 1);
    beat(0, 20, 0, 0, 1);
    beat(40, 0, 0, 0, 1);
    beat(0, 0, 0, 0, 1);
    idle_chk();

    // asynchronous reset mid-division
    do_start(45);
    beat(33, 0, 0, 0, 1);
    beat(0, 12, 0, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    m_run = 0;
    m_r = 0;
    m_rem = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(25, 0, 0, 0, 1);
    beat(25, 0, 0, 0, 1);

    // random divisions
    for (int k = 0; k < 8; k++) begin
      d = 32 + $urandom_range(0, 31);
      do_start(d);
      for (int i = 0; i < 60 && m_run; i++) begin
        lp = $urandom_range(0, 15);
        lm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : lp;
        beat($urandom_range(0, 63), $urandom_range(0, 63), lp, lm,
             (i >= 40) || ($urandom_range(0, 9) < 7));
      end
      idle_chk();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
